// File: rtl/div_unit.sv
// Purpose : 32-bit radix-2 restoring divider answering EX-stage DIV/DIVU with {remainder, quotient}.
// Latency : ready_o rises after the 34th edge counting the accepting edge as 1; divide-by-zero after the 2nd.
// Backpressure: result and ready_o are held while start_i stays high; dropping start_i returns to idle.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active-low
//   signed_div_i  1 = signed DIV, 0 = unsigned DIVU (sampled with start)
//   opdata1_i     dividend (sampled with start)
//   opdata2_i     divisor  (sampled with start)
//   start_i       request, held high until the result has been consumed
//   annul_i       cancel request (flush / exception), level-sensitive
//   result_o      {remainder[63:32], quotient[31:0]}, registered
//   ready_o       result valid, registered
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_DIVZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [64:0] w;        // {partial remainder, dividend / quotient bits, spare}
  logic [31:0] divisor;  // magnitude of the divisor
  logic        neg_q;    // quotient sign fix-up needed at the end
  logic        neg_r;    // remainder follows the dividend's sign

  logic [31:0] dvd_abs;
  logic [31:0] dvs_abs;
  logic [32:0] t;
  logic [31:0] q_raw;
  logic [31:0] r_raw;
  logic [31:0] q_fin;
  logic [31:0] r_fin;

  // Magnitudes; 0x80000000 stays 0x80000000 and is treated as unsigned.
  assign dvd_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign dvs_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // Trial subtraction; t[32] set means a borrow, so the quotient bit is 0.
  assign t = {1'b0, w[63:32]} - {1'b0, divisor};

  assign q_raw = w[31:0];
  assign r_raw = w[64:33];
  assign q_fin = neg_q ? (~q_raw + 32'd1) : q_raw;
  assign r_fin = neg_r ? (~r_raw + 32'd1) : r_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_FREE;
      cnt      <= 6'd0;
      w        <= 65'd0;
      divisor  <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      unique case (state)
        ST_FREE: begin
          result_o <= 64'd0;
          ready_o  <= 1'b0;
          // A request that arrives together with annul is dropped.
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= ST_DIVZERO;
            end else begin
              neg_q   <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
              neg_r   <= signed_div_i && opdata1_i[31];
              divisor <= dvs_abs;
              w       <= {32'd0, dvd_abs, 1'b0};
              cnt     <= 6'd0;
              state   <= ST_ON;
            end
          end
        end

        ST_ON: begin
          if (annul_i) begin
            state <= ST_FREE;
            cnt   <= 6'd0;
          end else if (cnt != 6'd32) begin
            if (t[32]) begin
              w <= {w[63:0], 1'b0};
            end else begin
              w <= {t[31:0], w[31:0], 1'b1};
            end
            cnt <= cnt + 6'd1;
          end else begin
            result_o <= {r_fin, q_fin};
            ready_o  <= 1'b1;
            cnt      <= 6'd0;
            state    <= ST_END;
          end
        end

        ST_DIVZERO: begin
          if (annul_i) begin
            state <= ST_FREE;
          end else begin
            result_o <= 64'd0;
            ready_o  <= 1'b1;
            state    <= ST_END;
          end
        end

        ST_END: begin
          // Result is held until EX releases start_i; annul has no effect here.
          if (!start_i) begin
            result_o <= 64'd0;
            ready_o  <= 1'b0;
            state    <= ST_FREE;
          end
        end

        default: state <= ST_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result_o;
  logic        ready_o;

  int n_chk  = 0;
  int n_fail = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: what {remainder, quotient} must be.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  // Transaction-level model: accepted request -> fixed delay -> result held until start drops.
  int          m_phase;   // 0 idle, 1 busy, 2 holding result
  int          m_cnt;
  logic [63:0] m_pend;
  logic        exp_rdy;
  logic [63:0] exp_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0;
      m_cnt   = 0;
      m_pend  = 64'd0;
      exp_rdy = 1'b0;
      exp_res = 64'd0;
    end else begin
      case (m_phase)
        0: begin
          exp_rdy = 1'b0;
          exp_res = 64'd0;
          if (start && !annul) begin
            m_pend  = ref_div(signed_div, op1, op2);
            m_cnt   = (op2 == 32'd0) ? 1 : 33;
            m_phase = 1;
          end
        end
        1: begin
          if (annul) begin
            m_phase = 0;
          end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
              m_phase = 2;
              exp_rdy = 1'b1;
              exp_res = m_pend;
            end
          end
        end
        default: begin
          if (!start) begin
            m_phase = 0;
            exp_rdy = 1'b0;
            exp_res = 64'd0;
          end
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    n_chk++;
    if (ready_o !== exp_rdy || result_o !== exp_res) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t ready=%b result=%h required ready=%b result=%h",
               $time, ready_o, result_o, exp_rdy, exp_res);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  // Issue one divide, measure latency, verify result, then release and verify clearing.
  task automatic run_div(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    int edges;
    bit got;
    signed_div = s;
    op1   = a;
    op2   = b;
    start = 1'b1;
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 60) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) begin
        // Operands must have been captured already.
        op1 = $urandom;
        op2 = $urandom;
        signed_div = ~s;
      end
      if (ready_o) got = 1'b1;
    end
    check({name, "_latency"}, 64'(edges), 64'(lat));
    check({name, "_result"}, result_o, exp);
    @(posedge clk);
    #1;
    check({name, "_hold"}, {63'd0, ready_o}, 64'd1);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_clear"}, {result_o[62:0], ready_o}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    signed_div = 1'b0;
    op1        = 32'd0;
    op2        = 32'd0;
    start      = 1'b0;
    annul      = 1'b0;
    #1;
    check("reset_state", {result_o[62:0], ready_o}, 64'd0);

    // Pin the reference model to hand-computed values.
    check("model_divu", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    check("model_div_neg", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    check("model_div_wrap", ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});
    check("model_div_zero", ref_div(1'b1, 32'h1234, 32'd0), 64'd0);

    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;

    run_div("divu_100_7",   1'b0, 32'd100,       32'd7,         {32'd2, 32'd14}, 34);
    run_div("div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    run_div("div_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 34);
    run_div("div_m100_m7",  1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 34);
    run_div("div_by0",      1'b1, 32'h1234,      32'd0,         64'd0, 2);
    run_div("divu_by0",     1'b0, 32'h1234,      32'd0,         64'd0, 2);
    run_div("divu_max_1",   1'b0, 32'hFFFF_FFFF, 32'd1,         {32'd0, 32'hFFFF_FFFF}, 34);
    run_div("div_min_m1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 34);
    run_div("divu_min_3",   1'b0, 32'h8000_0000, 32'd3,         {32'd2, 32'h2AAA_AAAA}, 34);

    // Annul while busy: no ready pulse may follow.
    begin
      int seen;
      signed_div = 1'b0;
      op1   = 32'd1000;
      op2   = 32'd7;
      start = 1'b1;
      repeat (11) @(posedge clk);
      #2;
      annul = 1'b1;
      @(posedge clk);
      #2;
      annul = 1'b0;
      start = 1'b0;
      seen  = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (ready_o) seen++;
      end
      check("annul_no_ready", 64'(seen), 64'd0);

      // Start together with annul in idle is ignored.
      start = 1'b1;
      annul = 1'b1;
      seen  = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (ready_o) seen++;
      end
      check("start_annul_ignored", 64'(seen), 64'd0);
      #1;
      start = 1'b0;
      annul = 1'b0;
      @(posedge clk);
      #2;
    end
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

    // Asynchronous reset in the middle of a divide.
    signed_div = 1'b0;
    op1   = 32'd123456;
    op2   = 32'd789;
    start = 1'b1;
    repeat (21) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_reset_clear", {result_o[62:0], ready_o}, 64'd0);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    run_div("divu_50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 34);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
